// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - multi-cycle execute stage: ALU, branch/jump resolution, shift-add multiplier
module execute_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] oprnd_1,
    input  logic [WIDTH-1:0] oprnd_2,
    input  logic [WIDTH-1:0] sext_imm,
    input  logic [WIDTH-1:0] pc_inc,
    input  logic [2:0]       alu_op,
    input  logic             alu_cin,
    input  logic             alu_inva,
    input  logic             alu_invb,
    input  logic             alu_sign,
    input  logic             mul_instr,
    input  logic             br_instr,
    input  logic             jmp_instr,
    input  logic             jr_instr,
    input  logic [1:0]       br_cnd_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out_q,
    output logic             ofl_q,
    output logic             zero_q,
    output logic             pc_src_q,
    output logic [WIDTH-1:0] pc_target_q,
    output logic             err_q,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_out_d, pc_target_d;
    logic               ofl_d, zero_d, pc_src_d, err_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d, msign_q, msign_d;
    logic [SHW:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]   a_x, b_x, alu_res, a_mag, b_mag, tgt;
    logic [SHW-1:0]     sh;
    logic [SHW:0]       rsh;
    logic [WIDTH:0]     sum;
    logic [2:0]         n_ctl;
    logic               add_ofl, cond, multi_ctl, accept, take_mul, mul_ofl;
    logic [2*WIDTH-1:0] prod_step, prod_fin;

    assign a_x = oprnd_1 ^ {WIDTH{alu_inva}};
    assign b_x = oprnd_2 ^ {WIDTH{alu_invb}};
    assign sh  = b_x[SHW-1:0];
    assign rsh = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign sum = {1'b0, a_x} + {1'b0, b_x} + {{WIDTH{1'b0}}, alu_cin};

    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000: alu_res = (a_x << sh) | (a_x >> rsh);
            3'b001: alu_res = a_x << sh;
            3'b010: alu_res = (a_x >> sh) | (a_x << rsh);
            3'b011: alu_res = a_x >> sh;
            3'b100: alu_res = sum[WIDTH-1:0];
            3'b101: alu_res = a_x | b_x;
            3'b110: alu_res = a_x ^ b_x;
            default: alu_res = a_x & b_x;
        endcase
    end

    assign add_ofl = alu_sign ? ((a_x[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a_x[WIDTH-1]))
                              : sum[WIDTH];

    always_comb begin
        cond = 1'b0;
        case (br_cnd_sel)
            2'b00: cond = (oprnd_1 == '0);
            2'b01: cond = (oprnd_1 != '0);
            2'b10: cond = oprnd_1[WIDTH-1];
            default: cond = ~oprnd_1[WIDTH-1];
        endcase
    end

    assign n_ctl     = {2'b00, mul_instr} + {2'b00, br_instr} + {2'b00, jmp_instr} + {2'b00, jr_instr};
    assign multi_ctl = (n_ctl > 3'd1);
    assign tgt       = (jr_instr ? oprnd_1 : pc_inc) + sext_imm;

    assign in_ready = (state_q == IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign take_mul = mul_instr & ~multi_ctl;

    // Signed multiply runs on magnitudes; the sign is restored on the last step.
    assign a_mag = (alu_sign & oprnd_1[WIDTH-1]) ? -oprnd_1 : oprnd_1;
    assign b_mag = (alu_sign & oprnd_2[WIDTH-1]) ? -oprnd_2 : oprnd_2;

    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_fin  = neg_q ? -prod_step : prod_step;
    assign mul_ofl   = msign_q ? ~((&prod_fin[2*WIDTH-1:WIDTH-1]) | ~(|prod_fin[2*WIDTH-1:WIDTH-1]))
                               : (|prod_fin[2*WIDTH-1:WIDTH]);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        ofl_d       = ofl_q;
        zero_d      = zero_q;
        pc_src_d    = pc_src_q;
        pc_target_d = pc_target_q;
        err_d       = err_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        msign_d     = msign_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d       = multi_ctl;
                    pc_target_d = tgt;
                    if (take_mul) begin
                        state_d     = MUL;
                        out_valid_d = 1'b0;
                        pc_src_d    = 1'b0;
                        prod_d      = '0;
                        mcand_d     = {{WIDTH{1'b0}}, a_mag};
                        mplier_d    = b_mag;
                        neg_d       = alu_sign & (oprnd_1[WIDTH-1] ^ oprnd_2[WIDTH-1]);
                        msign_d     = alu_sign;
                        cnt_d       = (SHW+1)'(WIDTH);
                    end else begin
                        out_valid_d = 1'b1;
                        alu_out_d   = alu_res;
                        ofl_d       = (alu_op == 3'b100) & add_ofl;
                        zero_d      = (alu_res == '0);
                        pc_src_d    = ~multi_ctl & (jmp_instr | jr_instr | (br_instr & cond));
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            MUL: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    alu_out_d   = prod_fin[WIDTH-1:0];
                    ofl_d       = mul_ofl;
                    zero_d      = (prod_fin[WIDTH-1:0] == '0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            ofl_q       <= 1'b0;
            zero_q      <= 1'b0;
            pc_src_q    <= 1'b0;
            pc_target_q <= '0;
            err_q       <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            msign_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            ofl_q       <= ofl_d;
            zero_q      <= zero_d;
            pc_src_q    <= pc_src_d;
            pc_target_q <= pc_target_d;
            err_q       <= err_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            msign_q     <= msign_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q == MUL);
endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - directed self-checking bench for execute_mc with a reference model
module tb_execute_mc;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] oprnd_1, oprnd_2, sext_imm, pc_inc, alu_out_q, pc_target_q;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_inva, alu_invb, alu_sign;
    logic        mul_instr, br_instr, jmp_instr, jr_instr;
    logic [1:0]  br_cnd_sel;
    logic        ofl_q, zero_q, pc_src_q, err_q, busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] alu;
        logic        ofl;
        logic        zero;
        logic        pc_src;
        logic [15:0] tgt;
        logic        err;
    } exp_t;

    exp_t expq[$];
    exp_t ch;

    always #5 clk = ~clk;

    execute_mc dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .oprnd_1(oprnd_1), .oprnd_2(oprnd_2), .sext_imm(sext_imm), .pc_inc(pc_inc),
        .alu_op(alu_op), .alu_cin(alu_cin), .alu_inva(alu_inva), .alu_invb(alu_invb),
        .alu_sign(alu_sign), .mul_instr(mul_instr), .br_instr(br_instr), .jmp_instr(jmp_instr),
        .jr_instr(jr_instr), .br_cnd_sel(br_cnd_sel), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out_q(alu_out_q), .ofl_q(ofl_q), .zero_q(zero_q), .pc_src_q(pc_src_q),
        .pc_target_q(pc_target_q), .err_q(err_q), .busy(busy)
    );

    // Expected result of the instruction currently on the input pins.
    function automatic exp_t model();
        exp_t        e;
        logic [15:0] av, bv, r;
        int unsigned a, b, sh, s;
        longint      p;
        int          nctl;
        logic        cond;
        av   = alu_inva ? ~oprnd_1 : oprnd_1;
        bv   = alu_invb ? ~oprnd_2 : oprnd_2;
        a    = av;
        b    = bv;
        sh   = b % 16;
        nctl = int'(mul_instr) + int'(br_instr) + int'(jmp_instr) + int'(jr_instr);
        e.err = (nctl > 1);
        e.ofl = 1'b0;
        r     = '0;
        if (mul_instr && !e.err) begin
            if (alu_sign) p = longint'($signed(oprnd_1)) * longint'($signed(oprnd_2));
            else          p = longint'(oprnd_1) * longint'(oprnd_2);
            r     = p[15:0];
            e.ofl = alu_sign ? (p < -32768 || p > 32767) : (p > 65535);
        end else begin
            case (alu_op)
                3'd0: r = 16'((a << sh) | (a >> (16 - sh)));
                3'd1: r = 16'(a << sh);
                3'd2: r = 16'((a >> sh) | (a << (16 - sh)));
                3'd3: r = 16'(a >> sh);
                3'd4: begin
                    s = a + b + alu_cin;
                    r = 16'(s);
                    e.ofl = alu_sign ? (av[15] == bv[15] && r[15] != av[15]) : (s > 65535);
                end
                3'd5: r = av | bv;
                3'd6: r = av ^ bv;
                default: r = av & bv;
            endcase
        end
        case (br_cnd_sel)
            2'd0: cond = (oprnd_1 == 16'h0);
            2'd1: cond = (oprnd_1 != 16'h0);
            2'd2: cond = oprnd_1[15];
            default: cond = !oprnd_1[15];
        endcase
        e.pc_src = !e.err && (jmp_instr || jr_instr || (br_instr && cond));
        e.tgt    = 16'((jr_instr ? oprnd_1 : pc_inc) + sext_imm);
        e.alu    = r;
        e.zero   = (r == 16'h0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid alu=%h (no result outstanding)", alu_out_q);
                end else begin
                    ch = expq[0];
                    if (alu_out_q !== ch.alu || ofl_q !== ch.ofl || zero_q !== ch.zero ||
                        pc_src_q !== ch.pc_src || pc_target_q !== ch.tgt || err_q !== ch.err) begin
                        fails++;
                        $display("FAIL result actual/required alu=%h/%h ofl=%b/%b zero=%b/%b src=%b/%b tgt=%h/%h err=%b/%b",
                                 alu_out_q, ch.alu, ofl_q, ch.ofl, zero_q, ch.zero, pc_src_q, ch.pc_src,
                                 pc_target_q, ch.tgt, err_q, ch.err);
                    end
                    if (out_ready || flush) void'(expq.pop_front());
                end
            end
            if (flush) expq.delete();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_defaults();
        flush = 0; in_valid = 0; out_ready = 1;
        oprnd_1 = 0; oprnd_2 = 0; sext_imm = 0; pc_inc = 0;
        alu_op = 3'd4; alu_cin = 0; alu_inva = 0; alu_invb = 0; alu_sign = 0;
        mul_instr = 0; br_instr = 0; jmp_instr = 0; jr_instr = 0; br_cnd_sel = 0;
    endtask

    task automatic issue(output int waited);
        int n = 0;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        waited = n;
        @(posedge clk);
        #1;
        expq.push_back(model());
        in_valid = 0;
    endtask

    task automatic wait_valid(output int waited);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL result_timeout out_valid=%b required=1", out_valid);
        end
        waited = n;
    endtask

    logic [2:0]  t_op  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [15:0] t_a   [10] = '{16'h8001, 16'h1234, 16'h00FF, 16'h8001, 16'hF000,
                                16'h0005, 16'h8000, 16'h0F0F, 16'hAAAA, 16'h1234};
    logic [15:0] t_b   [10] = '{16'h0004, 16'h0010, 16'h0004, 16'h0004, 16'h000C,
                                16'h0003, 16'hFFFF, 16'h00F0, 16'h5555, 16'hFF00};
    logic        t_ia  [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    logic        t_ib  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    logic        t_cin [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic        t_sg  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        int w, good;
        set_defaults();
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_alu", 32'(alu_out_q), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1;
        @(posedge clk); #1;

        oprnd_1 = 16'h7FFF; oprnd_2 = 16'h0001; alu_sign = 1;
        issue(w); wait_valid(w);
        chk("add_latency", 32'(w), 32'd0);
        chk("add_s_alu", 32'(alu_out_q), 32'h8000);
        chk("add_s_ofl", 32'(ofl_q), 32'h1);
        chk("add_s_zero", 32'(zero_q), 32'h0);
        @(posedge clk); #1;
        alu_sign = 0;
        issue(w); wait_valid(w);
        chk("add_u_ofl", 32'(ofl_q), 32'h0);
        @(posedge clk); #1;

        set_defaults();
        br_instr = 1; br_cnd_sel = 2'd2; oprnd_1 = 16'h8001; pc_inc = 16'h0010; sext_imm = 16'hFFF0;
        issue(w); wait_valid(w);
        chk("br_taken_src", 32'(pc_src_q), 32'h1);
        chk("br_taken_tgt", 32'(pc_target_q), 32'h0000);
        @(posedge clk); #1;
        oprnd_1 = 16'h0001;
        issue(w); wait_valid(w);
        chk("br_not_taken_src", 32'(pc_src_q), 32'h0);
        @(posedge clk); #1;
        set_defaults();
        jr_instr = 1; oprnd_1 = 16'h1000; sext_imm = 16'h0004; pc_inc = 16'h0200;
        issue(w); wait_valid(w);
        chk("jr_tgt", 32'(pc_target_q), 32'h1004);
        chk("jr_src", 32'(pc_src_q), 32'h1);
        @(posedge clk); #1;

        set_defaults();
        for (int i = 0; i < 10; i++) begin
            alu_op = t_op[i]; oprnd_1 = t_a[i]; oprnd_2 = t_b[i];
            alu_inva = t_ia[i]; alu_invb = t_ib[i]; alu_cin = t_cin[i]; alu_sign = t_sg[i];
            issue(w);
            if (i == 0) begin
                wait_valid(w);
                chk("rotl_alu", 32'(alu_out_q), 32'h0018);
                @(posedge clk); #1;
            end else if (i == 3) begin
                wait_valid(w);
                chk("rotr_alu", 32'(alu_out_q), 32'h1800);
                @(posedge clk); #1;
            end
        end
        repeat (2) @(posedge clk);
        #1;

        set_defaults();
        mul_instr = 1; oprnd_1 = 16'h0123; oprnd_2 = 16'h0010;
        issue(w);
        good = 0;
        repeat (16) begin
            @(negedge clk);
            if (busy && !in_ready && !out_valid) good++;
        end
        chk("mul_busy_cycles", 32'(good), 32'd16);
        @(negedge clk);
        chk("mul_valid", 32'(out_valid), 32'h1);
        chk("mul_busy_done", 32'(busy), 32'h0);
        chk("mul_u_alu", 32'(alu_out_q), 32'h1230);
        chk("mul_u_ofl", 32'(ofl_q), 32'h0);
        @(posedge clk); #1;
        oprnd_1 = 16'h0100; oprnd_2 = 16'h0100;
        issue(w); wait_valid(w);
        chk("mul_latency", 32'(w), 32'd16);
        chk("mul_ov_alu", 32'(alu_out_q), 32'h0000);
        chk("mul_ov_ofl", 32'(ofl_q), 32'h1);
        chk("mul_ov_zero", 32'(zero_q), 32'h1);
        @(posedge clk); #1;
        alu_sign = 1; oprnd_1 = 16'hFFFD; oprnd_2 = 16'h0005;
        issue(w); wait_valid(w);
        chk("mul_s_alu", 32'(alu_out_q), 32'hFFF1);
        chk("mul_s_ofl", 32'(ofl_q), 32'h0);
        @(posedge clk); #1;
        oprnd_1 = 16'h8000; oprnd_2 = 16'hFFFF;
        issue(w); wait_valid(w);
        @(posedge clk); #1;
        oprnd_1 = 16'h0100; oprnd_2 = 16'h0100;
        issue(w); wait_valid(w);
        @(posedge clk); #1;

        set_defaults();
        out_ready = 0; oprnd_1 = 16'h0001; oprnd_2 = 16'h0002;
        issue(w); wait_valid(w);
        good = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid && alu_out_q == 16'h0003 && !in_ready) good++;
        end
        chk("backpressure_hold", 32'(good), 32'd5);
        @(posedge clk); #1;
        out_ready = 1; oprnd_1 = 16'h0010; oprnd_2 = 16'h0020;
        issue(w);
        chk("no_bubble_wait", 32'(w), 32'd0);
        wait_valid(w);
        chk("no_bubble_alu", 32'(alu_out_q), 32'h0030);
        @(posedge clk); #1;

        set_defaults();
        mul_instr = 1; oprnd_1 = 16'h0005; oprnd_2 = 16'h0007;
        issue(w);
        repeat (7) @(negedge clk);
        @(posedge clk); #1;
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_out_valid", 32'(out_valid), 32'h0);
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_in_ready", 32'(in_ready), 32'h1);
        good = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) good++;
        end
        chk("flush_no_result", 32'(good), 32'd0);
        @(posedge clk); #1;
        set_defaults();
        flush = 1; in_valid = 1; oprnd_1 = 16'h0042;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush_blocks_accept", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        oprnd_1 = 16'h1111; oprnd_2 = 16'h2222;
        issue(w); wait_valid(w);
        chk("post_flush_alu", 32'(alu_out_q), 32'h3333);
        @(posedge clk); #1;

        set_defaults();
        oprnd_1 = 16'h00F0; oprnd_2 = 16'h0F0F; alu_op = 3'd5;
        issue(w); wait_valid(w);
        @(posedge clk); #1;
        set_defaults();
        mul_instr = 1; oprnd_1 = 16'h0003; oprnd_2 = 16'h0003; pc_inc = 16'h0010; sext_imm = 16'h0040;
        issue(w);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 0;
        expq.delete();
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_alu", 32'(alu_out_q), 32'h0);
        chk("arst_tgt", 32'(pc_target_q), 32'h0);
        chk("arst_flags", 32'({ofl_q, zero_q, pc_src_q, err_q}), 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        set_defaults();
        mul_instr = 1; br_instr = 1; br_cnd_sel = 2'd0; oprnd_1 = 16'h0000; oprnd_2 = 16'h0005;
        issue(w); wait_valid(w);
        chk("err_latency", 32'(w), 32'd0);
        chk("err_flag", 32'(err_q), 32'h1);
        chk("err_pc_src", 32'(pc_src_q), 32'h0);
        chk("err_alu", 32'(alu_out_q), 32'h0005);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "bench timeout");
    end
endmodule
